// File: rtl/ripple_count_monitor.sv
// rtl/ripple_count_monitor.sv - synchronizes a glitchy ripple count, tracks matches/wraps, reports them over a 4-phase handshake
// Optional wrap tracking (wrap_cnt, evt_type[1]) is built only when RCM_WRAP_EXT_EN is defined.
module ripple_count_monitor #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             cmp_en,
  input  logic             evt_ack,
  output logic [WIDTH-1:0] count_out,
  output logic [7:0]       wrap_cnt,
  output logic             evt_req,
  output logic [1:0]       evt_type,
  output logic             evt_lost
);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] s1, s2, s2_prev;
  logic             loaded;
  logic             accept;
  logic             flag_match, flag_wrap;
  logic [1:0]       flags;
  logic [1:0]       pending;
  logic [1:0]       type_q;
  logic             take;

  // A value is trusted only after it has been seen unchanged on two consecutive samples.
  assign accept = (s2 == s2_prev) && (s2 != count_out);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1        <= '0;
      s2        <= '0;
      s2_prev   <= '0;
      count_out <= '0;
      loaded    <= 1'b0;
    end else begin
      s1      <= cnt_in;
      s2      <= s1;
      s2_prev <= s2;
      if (accept) begin
        count_out <= s2;
        loaded    <= 1'b1;
      end
    end
  end

  // The first acceptance after reset only establishes a baseline.
  assign flag_match = accept && loaded && cmp_en && (s2 == cmp_val);

`ifdef RCM_WRAP_EXT_EN
  logic [7:0] wrap_q;

  assign flag_wrap = accept && loaded && (s2 < count_out);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrap_q <= 8'h00;
    end else if (flag_wrap && (wrap_q != 8'hFF)) begin
      wrap_q <= wrap_q + 8'd1;
    end
  end

  assign wrap_cnt = wrap_q;
`else
  assign flag_wrap = 1'b0;
  assign wrap_cnt  = 8'h00;
`endif

  assign flags = {flag_wrap, flag_match};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (pending != 2'b00) begin
          state_nxt = REQ;
          take      = 1'b1;
        end
      end
      REQ:     if (evt_ack)  state_nxt = DROP;
      DROP:    if (!evt_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Events flagged in the hand-off cycle stay pending rather than counting as lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending  <= 2'b00;
      type_q   <= 2'b00;
      evt_lost <= 1'b0;
    end else if (take) begin
      type_q  <= pending;
      pending <= flags;
    end else begin
      pending <= pending | flags;
      if ((flags & pending) != 2'b00) evt_lost <= 1'b1;
    end
  end

  assign evt_req  = (state == REQ);
  assign evt_type = evt_req ? type_q : 2'b00;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// tb/tb_ripple_count_monitor.sv - randomized and directed bench for ripple_count_monitor against a behavioural model
module tb_ripple_count_monitor;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] cnt_in = '0;
  logic [W-1:0] cmp_val = '0;
  logic         cmp_en = 1'b0;
  logic         evt_ack = 1'b0;
  logic [W-1:0] count_out;
  logic [7:0]   wrap_cnt;
  logic         evt_req;
  logic [1:0]   evt_type;
  logic         evt_lost;

  int tests = 0;
  int fails = 0;

  ripple_count_monitor #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .cnt_in    (cnt_in),
    .cmp_val   (cmp_val),
    .cmp_en    (cmp_en),
    .evt_ack   (evt_ack),
    .count_out (count_out),
    .wrap_cnt  (wrap_cnt),
    .evt_req   (evt_req),
    .evt_type  (evt_type),
    .evt_lost  (evt_lost)
  );

  always #5 clock = ~clock;

  // Reference model: samples of cnt_in per edge, newest first.
  int hist[4];
  int m_count, m_wrap, m_pend, m_type, m_state;
  bit m_loaded, m_lost;
  int dut_changes;
  int last_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) hist[i] = 0;
    m_count = 0; m_wrap = 0; m_pend = 0; m_type = 0; m_state = 0;
    m_loaded = 0; m_lost = 0;
  endfunction

  function automatic void model_edge();
    int fl;
    fl = 0;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = int'(cnt_in);
    // hist[2]/hist[3] are the two samples old enough to have crossed the synchronizer
    if (hist[2] == hist[3] && hist[2] != m_count) begin
      if (m_loaded) begin
        if (cmp_en && hist[2] == int'(cmp_val)) fl |= 1;
`ifdef RCM_WRAP_EXT_EN
        if (hist[2] < m_count) begin
          fl |= 2;
          if (m_wrap < 255) m_wrap++;
        end
`endif
      end
      m_count  = hist[2];
      m_loaded = 1;
    end
    if (m_state == 0 && m_pend != 0) begin
      m_type  = m_pend;
      m_pend  = fl;
      m_state = 1;
    end else begin
      if ((fl & m_pend) != 0) m_lost = 1;
      m_pend |= fl;
      if (m_state == 1 && evt_ack) m_state = 2;
      else if (m_state == 2 && !evt_ack) m_state = 0;
    end
  endfunction

  task automatic compare_all();
    check("count_out", count_out, m_count);
    check("wrap_cnt", wrap_cnt, m_wrap);
    check("evt_req", evt_req, (m_state == 1));
    check("evt_type", evt_type, (m_state == 1) ? m_type : 0);
    check("evt_lost", evt_lost, m_lost);
  endtask

  task automatic step(input bit auto_ack);
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
    if (int'(count_out) != last_seen) dut_changes++;
    last_seen = int'(count_out);
    if (auto_ack && $urandom_range(0, 2) != 0) evt_ack = evt_req;
  endtask

  task automatic hold(input int v, input int n, input bit auto_ack);
    cnt_in = W'(v);
    repeat (n) step(auto_ack);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #2 reset = 1'b0;
    evt_ack = 1'b0;
    model_reset();
    #1;
    compare_all();
    #2 reset = 1'b1;
    dut_changes = 0;
    last_seen = 0;
  endtask

  initial begin
    model_reset();
    dut_changes = 0;
    last_seen = 0;
    #3;
    compare_all();
    #3 reset = 1'b1;

    // Latency and compare match after a silent baseline load.
    cmp_val = 4'd5; cmp_en = 1'b1;
    hold(1, 6, 0);
    cnt_in = 4'd5;
    repeat (3) step(0);
    check("lat3", count_out, 1);
    step(0);
    check("lat4", count_out, 5);
    step(0);
    check("match_req", evt_req, 1);
    check("match_type", evt_type, 1);
    evt_ack = 1'b1; step(0);
    check("ack_drop", evt_req, 0);
    evt_ack = 1'b0; step(0);
    step(0);
    check("idle_noreq", evt_req, 0);

    // Wrap 15 -> 0.
    pulse_reset();
    cmp_en = 1'b0;
    hold(15, 6, 0);
    hold(0, 5, 0);
`ifdef RCM_WRAP_EXT_EN
    check("wrap_once", wrap_cnt, 1);
    check("wrap_type", evt_type, 2);
`else
    check("wrap_once", wrap_cnt, 0);
    check("wrap_type", evt_type, 0);
`endif
    evt_ack = 1'b1; step(0);
    evt_ack = 1'b0; step(0);

    // Glitching input: only the settled 8 is accepted.
    pulse_reset();
    cnt_in = 4'd7; step(0);
    cnt_in = 4'd6; step(0);
    cnt_in = 4'd4; step(0);
    hold(8, 6, 0);
    check("glitch_val", count_out, 8);
    check("glitch_acc", dut_changes, 1);

    // Repeated matches while the request is held produce a lost flag.
    pulse_reset();
    cmp_val = 4'd5; cmp_en = 1'b1;
    hold(1, 4, 0);
    hold(5, 4, 0);
    hold(7, 4, 0);
    hold(5, 4, 0);
    hold(7, 4, 0);
    hold(5, 4, 0);
    check("lost_set", evt_lost, 1);
    evt_ack = 1'b1; step(0);
    evt_ack = 1'b0; step(0);
    step(0);
    check("second_req", evt_req, 1);
`ifdef RCM_WRAP_EXT_EN
    check("second_type", evt_type, 3);
`else
    check("second_type", evt_type, 1);
`endif

    // Reset in the middle of a request.
    pulse_reset();
    check("rst_req", evt_req, 0);
    check("rst_lost", evt_lost, 0);
    check("rst_count", count_out, 0);
    repeat (10) step(0);
    check("rst_noreq", evt_req, 0);

    // Saturating wrap counter.
    pulse_reset();
    cmp_en = 1'b0;
    hold(15, 3, 1);
    for (int i = 0; i < 300; i++) begin
      hold(0, 2, 1);
      hold(15, 2, 1);
    end
    repeat (6) step(1);
`ifdef RCM_WRAP_EXT_EN
    check("wrap_sat", wrap_cnt, 255);
`else
    check("wrap_sat", wrap_cnt, 0);
`endif

    // Randomized traffic.
    pulse_reset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) cmp_val = W'($urandom_range(0, 15));
      cmp_en = ($urandom_range(0, 3) != 0);
      hold(int'($urandom_range(0, 15)), int'($urandom_range(1, 4)), 1);
      if ($urandom_range(0, 60) == 0) pulse_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
